// File: rtl/fwd_hazard_unit_pkg.sv
// Shared core definitions: forward-select encodings and the pipeline tracking entry
// used by the forwarding/hazard unit and its per-operand lanes.
package core_pkg;

    // Wide enough for any supported register address width; narrower addresses are zero-extended.
    localparam int REG_AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } trk_entry_t;

    function automatic logic is_writer(trk_entry_t e);
        return e.valid && e.reg_write && (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the D/E pipeline register, the forwarding/hazard unit and the execute stage.
interface fwd_hazard_if #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 32
);
    logic                      hold;
    logic                      flushD;
    logic                      d_valid;
    logic [NUM_OPS*REG_AW-1:0] d_rs;
    logic [NUM_OPS-1:0]        d_rs_used;
    logic [REG_AW-1:0]         d_rd;
    logic                      d_reg_write;
    logic                      d_is_load;
    logic [NUM_OPS*XLEN-1:0]   e_rd_data;
    logic [XLEN-1:0]           FU_resultM;
    logic [XLEN-1:0]           ResultW;
    logic                      stallD;
    logic [2*NUM_OPS-1:0]      fwd_selE;
    logic [NUM_OPS*XLEN-1:0]   operandE;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output hold, flushD, d_valid, d_rs, d_rs_used, d_rd, d_reg_write, d_is_load,
               e_rd_data, FU_resultM, ResultW,
        input  stallD, fwd_selE, operandE, stall_count
    );

    modport slave (
        input  hold, flushD, d_valid, d_rs, d_rs_used, d_rd, d_reg_write, d_is_load,
               e_rd_data, FU_resultM, ResultW,
        output stallD, fwd_selE, operandE, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit_lane.sv
// One execute operand: compares its source against the M and W writers, picks the
// forward select (M over W) and muxes the operand value.
module fwd_sel_lane
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_AW_MAX-1:0] rs_i,
    input  logic                  rs_used_i,
    input  trk_entry_t            m_i,
    input  trk_entry_t            w_i,
    input  logic [XLEN-1:0]       rf_data_i,
    input  logic [XLEN-1:0]       m_data_i,
    input  logic [XLEN-1:0]       w_data_i,
    output fwd_sel_e              sel_o,
    output logic [XLEN-1:0]       operand_o
);

    // A load in M has no data yet, so it is never a forwarding source.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the output unassigned (no latch).
        sel_o = FWD_RF;
        if (rs_used_i && is_writer(m_i) && !m_i.is_load && (m_i.rd == rs_i)) begin
            sel_o = FWD_M;
        end else if (rs_used_i && is_writer(w_i) && (w_i.rd == rs_i)) begin
            sel_o = FWD_W;
        end
    end

    always_comb begin
        case (sel_o)
            FWD_M:   operand_o = m_data_i;
            FWD_W:   operand_o = w_data_i;
            default: operand_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks E/M/W destination metadata, drives per-operand
// forward selects and operands, inserts load-use bubbles and counts stall cycles.
module fwd_hazard_unit
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 32
) (
    input logic         clk,
    input logic         rst_n,
    fwd_hazard_if.slave bus
);

    trk_entry_t e_q, e_d, m_q, m_d, w_q, w_d;
    logic [NUM_OPS-1:0][REG_AW_MAX-1:0] e_rs_q, e_rs_d, d_rs_ext;
    logic [NUM_OPS-1:0]                 e_rs_used_q, e_rs_used_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               load_use;
    logic                               stall;
    logic                               bubble;

    always_comb begin
        for (int k = 0; k < NUM_OPS; k++) begin
            d_rs_ext[k] = REG_AW_MAX'(bus.d_rs[k*REG_AW +: REG_AW]);
        end
    end

    // Flush has priority: a killed instruction cannot cause a stall.
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (bus.d_rs_used[k] && (d_rs_ext[k] == e_q.rd)) begin
                load_use = 1'b1;
            end
        end
        stall = bus.d_valid && !bus.flushD && e_q.is_load && is_writer(e_q) && load_use;
    end

    assign bubble = stall || bus.flushD || !bus.d_valid;

    always_comb begin
        e_d         = e_q;
        e_rs_d      = e_rs_q;
        e_rs_used_d = e_rs_used_q;
        m_d         = m_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        if (!bus.hold) begin
            m_d = e_q;
            w_d = m_q;
            if (bubble) begin
                e_d         = '0;
                e_rs_d      = '0;
                e_rs_used_d = '0;
            end else begin
                e_d.valid     = 1'b1;
                e_d.rd        = REG_AW_MAX'(bus.d_rd);
                e_d.reg_write = bus.d_reg_write;
                e_d.is_load   = bus.d_is_load;
                e_rs_d        = d_rs_ext;
                e_rs_used_d   = bus.d_rs_used;
            end
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            e_rs_q      <= '0;
            e_rs_used_q <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking so M takes the old E and W the old M within the same edge.
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            e_rs_q      <= e_rs_d;
            e_rs_used_q <= e_rs_used_d;
            cnt_q       <= cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_lane
        fwd_sel_e        sel;
        logic [XLEN-1:0] operand;

        fwd_sel_lane #(.XLEN(XLEN)) u_lane (
            .rs_i      (e_rs_q[k]),
            .rs_used_i (e_rs_used_q[k]),
            .m_i       (m_q),
            .w_i       (w_q),
            .rf_data_i (bus.e_rd_data[k*XLEN +: XLEN]),
            .m_data_i  (bus.FU_resultM),
            .w_data_i  (bus.ResultW),
            .sel_o     (sel),
            .operand_o (operand)
        );

        assign bus.fwd_selE[2*k +: 2]       = sel;
        assign bus.operandE[k*XLEN +: XLEN] = operand;
    end

    assign bus.stallD      = stall;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: stimulus pushes expected outputs into a scoreboard
// queue and a separate monitor pops and compares them against the DUT.
module tb_fwd_hazard_unit;
    import core_pkg::*;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_OPS = 2;
    localparam int CNT_W   = 4;

    localparam logic [63:0] RD_DATA = 64'h2222_2222_1111_1111;
    localparam logic [31:0] FU_M    = 32'h0000_0011;
    localparam logic [31:0] RES_W   = 32'hDEAD_BEEF;

    typedef struct {
        string       name;
        logic        stall;
        logic [3:0]  sel;
        logic [63:0] op;
        logic [3:0]  cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    event sample_ev;
    logic [3:0] exp_cnt;

    fwd_hazard_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: consumes expectations whenever the stimulus flags a sampling point.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".stallD"},      64'(bus.stallD),      64'(e.stall));
                check({e.name, ".fwd_selE"},    64'(bus.fwd_selE),    64'(e.sel));
                check({e.name, ".operandE"},    64'(bus.operandE),    e.op);
                check({e.name, ".stall_count"}, 64'(bus.stall_count), 64'(e.cnt));
            end
        end
    end

    // A load sitting in M that matches a live E source must never happen.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                assert (!(is_writer(dut.m_q) && dut.m_q.is_load && dut.e_rs_used_q[k] &&
                          (dut.e_rs_q[k] == dut.m_q.rd)))
                else begin
                    errors++;
                    $display("FAIL load_in_M_hazard: op %0d got load in M matching E source, required none", k);
                end
            end
        end
    end

    task automatic push(input string name, input logic stall, input logic [3:0] sel,
                        input logic [63:0] op, input logic [3:0] cnt);
        exp_t e;
        #1;
        e.name = name; e.stall = stall; e.sel = sel; e.op = op; e.cnt = cnt;
        sb_q.push_back(e);
        ->sample_ev;
    endtask

    task automatic drive_d(input logic valid, input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic [1:0] used, input logic [4:0] rd, input logic rw,
                           input logic ld);
        bus.d_valid     = valid;
        bus.d_rs        = {rs1, rs0};
        bus.d_rs_used   = used;
        bus.d_rd        = rd;
        bus.d_reg_write = rw;
        bus.d_is_load   = ld;
    endtask

    task automatic nop();
        drive_d(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1;
        bus.hold = 1'b0; bus.flushD = 1'b0;
        bus.e_rd_data = RD_DATA; bus.FU_resultM = FU_M; bus.ResultW = RES_W;
        nop();
        #1 rst_n = 1'b0;
        push("reset", 1'b0, 4'b0000, RD_DATA, 4'd0);
        #7 rst_n = 1'b1;

        // ADD x5 then SUB reading x5 (op0) and x6 (op1): op0 from M
        tick(); drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick(); drive_d(1'b1, 5'd5, 5'd6, 2'b11, 5'd8, 1'b1, 1'b0);
        tick(); nop();
        push("fwd_m", 1'b0, 4'b0010, {32'h2222_2222, FU_M}, 4'd0);

        // x5 written by both M and W: M wins
        drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick(); drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick(); drive_d(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
        tick(); nop();
        push("m_over_w", 1'b0, 4'b0010, {32'h2222_2222, FU_M}, 4'd0);

        // W-only writer of x5 read by op1
        tick(); drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick(); nop();
        tick(); drive_d(1'b1, 5'd3, 5'd5, 2'b11, 5'd10, 1'b1, 1'b0);
        tick(); nop();
        push("fwd_w_op1", 1'b0, 4'b0100, {RES_W, 32'h1111_1111}, 4'd0);

        // write x0 then read x0 on both operands
        drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
        tick(); drive_d(1'b1, 5'd0, 5'd0, 2'b11, 5'd11, 1'b1, 1'b0);
        tick(); nop();
        push("x0_no_fwd", 1'b0, 4'b0000, RD_DATA, 4'd0);

        // load-use: one stall cycle, bubble, then consumer forwarded from W
        drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick(); drive_d(1'b1, 5'd7, 5'd2, 2'b11, 5'd12, 1'b1, 1'b0);
        push("lu_stall", 1'b1, 4'b0000, RD_DATA, 4'd0);
        tick();
        push("lu_bubble", 1'b0, 4'b0000, RD_DATA, 4'd1);
        tick(); nop();
        push("lu_consumer", 1'b0, 4'b0001, {32'h2222_2222, RES_W}, 4'd1);

        // load-use with flush: no stall, bubble enters E (a leak would forward x5 from W to op1)
        drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick(); drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick(); drive_d(1'b1, 5'd7, 5'd5, 2'b11, 5'd13, 1'b1, 1'b0);
        bus.flushD = 1'b1;
        push("flush_no_stall", 1'b0, 4'b0000, RD_DATA, 4'd1);
        tick(); bus.flushD = 1'b0; nop();
        push("flush_bubble", 1'b0, 4'b0000, RD_DATA, 4'd1);

        // load-use under hold for three cycles
        drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick(); drive_d(1'b1, 5'd7, 5'd2, 2'b01, 5'd12, 1'b1, 1'b0);
        bus.hold = 1'b1;
        push("hold_0", 1'b1, 4'b0000, RD_DATA, 4'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            push($sformatf("hold_%0d", i), 1'b1, 4'b0000, RD_DATA, 4'd1);
        end
        bus.hold = 1'b0;
        push("hold_release", 1'b1, 4'b0000, RD_DATA, 4'd1);
        tick();
        push("hold_bubble", 1'b0, 4'b0000, RD_DATA, 4'd2);
        tick(); nop();
        push("hold_consumer", 1'b0, 4'b0001, {32'h2222_2222, RES_W}, 4'd2);

        // repeated load-use stalls drive the counter into saturation
        exp_cnt = 4'd2;
        for (int i = 0; i < 16; i++) begin
            drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
            tick(); drive_d(1'b1, 5'd7, 5'd2, 2'b01, 5'd12, 1'b1, 1'b0);
            push($sformatf("sat_stall_%0d", i), 1'b1, 4'b0000, RD_DATA, exp_cnt);
            tick();
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            nop();
            push($sformatf("sat_cnt_%0d", i), 1'b0, 4'b0000, RD_DATA, exp_cnt);
            tick();
        end

        // reset asserted mid-stall takes effect without a clock edge
        drive_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick(); drive_d(1'b1, 5'd7, 5'd2, 2'b01, 5'd12, 1'b1, 1'b0);
        push("pre_reset_stall", 1'b1, 4'b0000, RD_DATA, 4'hF);
        #1 rst_n = 1'b0;
        push("async_reset", 1'b0, 4'b0000, RD_DATA, 4'd0);
        #2 rst_n = 1'b1;
        tick(); drive_d(1'b1, 5'd12, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0);
        tick(); nop();
        push("post_reset_load", 1'b0, 4'b0010, {32'h2222_2222, FU_M}, 4'd0);

        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage RISC-V core, the next generation of the per-operand forwarding muxes. It tracks destination-register metadata for the instructions in E, M and W, generates forward selects for `NUM_OPS` execute-stage operands, and drives the muxed operands. It also detects load-use hazards, inserts one-cycle bubbles, honours branch flush and global hold, and counts stall cycles. It sits between the D/E pipeline register and the execute functional units.

## Interface
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register address width
- `NUM_OPS`, 2, number of execute operands (1..3)
- `CNT_W`, 32, stall counter width
- `clk` in 1: core clock
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `hold` in 1: global freeze (memory stall); all tracking state holds
- `flushD` in 1: kill the instruction advancing D→E (taken branch)
- `d_valid` in 1: D holds a valid instruction
- `d_rs` in NUM_OPS*REG_AW: source addresses, op k at [k*REG_AW +: REG_AW]
- `d_rs_used` in NUM_OPS: op k actually reads a register
- `d_rd` in REG_AW: destination address
- `d_reg_write` in 1: instruction writes rd
- `d_is_load` in 1: instruction is a load
- `e_rd_data` in NUM_OPS*XLEN: register-file values latched into E
- `FU_resultM` in XLEN: ALU/FU result in M
- `ResultW` in XLEN: writeback value in W
- `stallD` out 1: freeze F and D this cycle
- `fwd_selE` out 2*NUM_OPS: per-op select, 00 regfile, 01 W, 10 M
- `operandE` out NUM_OPS*XLEN: forwarded operands
- `stall_count` out CNT_W: saturating count of load-use stall cycles

## Operation
- Three tracking entries E, M, W hold {valid, rd, reg_write, is_load}. E also holds rs[NUM_OPS] and rs_used.
- An entry is a writer when valid && reg_write && rd != 0.
- Forward select for op k, evaluated on E:
  - 10 if E.rs_used[k] and the M entry is a writer, is not a load, and M.rd == E.rs[k].
  - else 01 if E.rs_used[k] and the W entry is a writer and W.rd == E.rs[k].
  - else 00.
- M has priority over W.
- Select 11 is never produced. `operandE` muxes it as 00.
- Source address x0 never forwards.
- Load-use: `stallD` = d_valid && !flushD && E is a valid load writer && some k has d_rs_used[k] && d_rs[k] == E.rd.
- Tracking update at clk↑ when !hold:
  - E ← bubble if (stallD | flushD | !d_valid), else the D fields.
  - M ← E.
  - W ← M.
- When hold = 1, all entries and `stall_count` keep their value. Outputs still reflect the current state.
- flushD together with a load-use condition: flush wins; `stallD` = 0 and a bubble enters E.
- `stall_count` increments on each clk↑ with stallD && !hold. It saturates at all-ones.
- A load in M matching an E source is illegal, because the stall prevents it. The bench asserts it never occurs.

## Timing
- `fwd_selE`, `operandE` and `stallD` are combinational from the tracking registers and D inputs. There is no added latency.
- A load-use stall lasts exactly one cycle (absent hold). In the following cycle the load is in M, a bubble is in E, and D re-evaluates with `stallD` = 0.
- The consumer then reaches E when the load is in W and gets select 01.
- Reset (rst_n low, asynchronous):
  - all valid bits 0
  - `stall_count` 0
  - hence `stallD` 0, `fwd_selE` 0, and `operandE` = `e_rd_data`.
- Reset mid-stall: the bubble and the load are discarded, and the first edge after deassertion loads D normally.

## Structure
- Shared package `core_pkg` holds the forward-select encodings (FWD_RF, FWD_W, FWD_M) and the tracking-entry struct typedef.
- One sub-module, `fwd_sel_lane`, is instantiated NUM_OPS times. It does per-operand compare, select and mux.
- Tracking registers, stall logic and the counter live in the top level.

## Test plan
- ADD x5 followed immediately by SUB reading x5 as op0 → `fwd_selE`[1:0] = 10 and operand0 = FU_resultM (0x0000_0011).
- x5 written by the instructions in both M and W → M wins, select 10.
- The W-only writer of x5 has its operand forwarded from `ResultW` = 0xDEAD_BEEF, select 01.
- A write to x0 followed by a read of x0 → select 00 and `operandE` = `e_rd_data`.
- LW x7 followed by ADD reading x7 → `stallD` = 1 for exactly one cycle, with a bubble in E. `stall_count` goes 0→1. The ADD then sees select 01.
- Same load-use pair with flushD = 1 → `stallD` = 0 and a bubble enters E.
- Same load-use pair with hold = 1 for 3 cycles → `stall_count` stays 0 until hold drops, then 1. `stallD` stays 1 throughout.
- Counter preloaded near max, repeated load-use stalls → saturates at 2^CNT_W−1.
- rst_n pulsed low mid-stall → all outputs return to their reset values immediately, without waiting for a clock edge.
